// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: one radix-2^SliceW slice of the multiplier per stage,
// result held in the last stage until the CDB arbiter grants it.
module mult_fu #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned N_STAGES  = 4,
  parameter int unsigned PR_IDX_W  = 6,
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_func,
  input  logic [XLEN-1:0]      issue_opa,
  input  logic [XLEN-1:0]      issue_opb,
  input  logic [PR_IDX_W-1:0]  issue_pr_idx,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  output logic                 busy,
  output logic                 cdb_req,
  input  logic                 cdb_gnt,
  output logic [XLEN-1:0]      cdb_result,
  output logic [PR_IDX_W-1:0]  cdb_pr_idx,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx
);

  localparam int unsigned DW     = 2 * XLEN;
  localparam int unsigned SliceW = DW / N_STAGES;

  localparam logic [1:0] FnMul   = 2'd0;
  localparam logic [1:0] FnMulh  = 2'd1;
  localparam logic [1:0] FnMulhu = 2'd3;

  typedef logic [DW-1:0] dword_t;

  // Per-stage state; index 0 is the stage fed by the issue port.
  logic [N_STAGES-1:0]  valid_q, valid_d;
  logic [N_STAGES-1:0]  adv;
  logic [1:0]           func_q    [N_STAGES];
  logic [PR_IDX_W-1:0]  pr_idx_q  [N_STAGES];
  logic [ROB_IDX_W-1:0] rob_idx_q [N_STAGES];
  dword_t               mcand_q   [N_STAGES];
  dword_t               mplier_q  [N_STAGES];
  dword_t               partial_q [N_STAGES];

  // Values each stage loads when it advances.
  logic [1:0]           func_ld    [N_STAGES];
  logic [PR_IDX_W-1:0]  pr_idx_ld  [N_STAGES];
  logic [ROB_IDX_W-1:0] rob_idx_ld [N_STAGES];
  dword_t               mcand_ld   [N_STAGES];
  dword_t               mplier_ld  [N_STAGES];
  dword_t               partial_ld [N_STAGES];

  logic   opa_sext, opb_sext, accept;
  dword_t issue_mcand, issue_mplier;

  assign opa_sext     = (issue_func != FnMulhu);
  assign opb_sext     = (issue_func == FnMul) || (issue_func == FnMulh);
  assign issue_mcand  = {{XLEN{opa_sext & issue_opa[XLEN-1]}}, issue_opa};
  assign issue_mplier = {{XLEN{opb_sext & issue_opb[XLEN-1]}}, issue_opb};

  // A stage moves if it is empty or everything downstream of it moves.
  always_comb begin
    logic a;
    a = ~valid_q[N_STAGES-1] | cdb_gnt;
    adv[N_STAGES-1] = a;
    for (int k = N_STAGES - 2; k >= 0; k--) begin
      a      = ~valid_q[k] | a;
      adv[k] = a;
    end
  end

  assign busy   = valid_q[0] & ~adv[0];
  assign accept = issue_valid & ~busy & ~squash;

  always_comb begin
    func_ld[0]    = issue_func;
    pr_idx_ld[0]  = issue_pr_idx;
    rob_idx_ld[0] = issue_rob_idx;
    mcand_ld[0]   = issue_mcand;
    mplier_ld[0]  = issue_mplier;
    partial_ld[0] = issue_mcand * dword_t'(issue_mplier[SliceW-1:0]);
    for (int k = 1; k < N_STAGES; k++) begin
      func_ld[k]    = func_q[k-1];
      pr_idx_ld[k]  = pr_idx_q[k-1];
      rob_idx_ld[k] = rob_idx_q[k-1];
      mcand_ld[k]   = mcand_q[k-1];
      mplier_ld[k]  = mplier_q[k-1];
      partial_ld[k] = partial_q[k-1]
                    + ((mcand_q[k-1] * dword_t'(mplier_q[k-1][k*SliceW +: SliceW]))
                       << (k * SliceW));
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (squash) begin
      valid_d = '0;
    end else begin
      if (adv[0]) valid_d[0] = accept;
      for (int k = 1; k < N_STAGES; k++) begin
        if (adv[k]) valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < N_STAGES; k++) begin
      if (adv[k]) begin
        func_q[k]    <= func_ld[k];
        pr_idx_q[k]  <= pr_idx_ld[k];
        rob_idx_q[k] <= rob_idx_ld[k];
        mcand_q[k]   <= mcand_ld[k];
        mplier_q[k]  <= mplier_ld[k];
        partial_q[k] <= partial_ld[k];
      end
    end
  end

  always_comb begin
    cdb_req     = valid_q[N_STAGES-1];
    cdb_result  = '0;
    cdb_pr_idx  = '0;
    cdb_rob_idx = '0;
    if (valid_q[N_STAGES-1]) begin
      cdb_result  = (func_q[N_STAGES-1] == FnMul) ? partial_q[N_STAGES-1][XLEN-1:0]
                                                   : partial_q[N_STAGES-1][DW-1:XLEN];
      cdb_pr_idx  = pr_idx_q[N_STAGES-1];
      cdb_rob_idx = rob_idx_q[N_STAGES-1];
    end
  end

  // Each stage only consumes its own multiplier slice; the rest rides along.
  logic unused_operands;
  always_comb begin
    unused_operands = ^mcand_q[N_STAGES-1];
    for (int k = 0; k < N_STAGES; k++) begin
      unused_operands = unused_operands ^ (^mplier_q[k]);
    end
  end

endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: driver pushes expected CDB responses, a forked monitor
// compares them whenever the unit requests the CDB.
module tb_mult_fu;

  localparam logic [1:0] MUL = 2'd0, MULH = 2'd1, MULHSU = 2'd2, MULHU = 2'd3;

  logic        clock = 1'b0;
  logic        reset, squash, issue_valid, cdb_gnt;
  logic [1:0]  issue_func;
  logic [31:0] issue_opa, issue_opb;
  logic [5:0]  issue_pr_idx;
  logic [4:0]  issue_rob_idx;
  logic        busy, cdb_req;
  logic [31:0] cdb_result;
  logic [5:0]  cdb_pr_idx;
  logic [4:0]  cdb_rob_idx;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  pr;
    logic [4:0]  rob;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   g;

  mult_fu dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .issue_valid  (issue_valid),
    .issue_func   (issue_func),
    .issue_opa    (issue_opa),
    .issue_opb    (issue_opb),
    .issue_pr_idx (issue_pr_idx),
    .issue_rob_idx(issue_rob_idx),
    .busy         (busy),
    .cdb_req      (cdb_req),
    .cdb_gnt      (cdb_gnt),
    .cdb_result   (cdb_result),
    .cdb_pr_idx   (cdb_pr_idx),
    .cdb_rob_idx  (cdb_rob_idx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (reset && cdb_req) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cdb_req: got result %h rob %0d, required no request",
                   cdb_result, cdb_rob_idx);
        end else begin
          check("cdb_result", cdb_result, sb[0].res);
          check("cdb_pr_idx", 32'(cdb_pr_idx), 32'(sb[0].pr));
          check("cdb_rob_idx", 32'(cdb_rob_idx), 32'(sb[0].rob));
          if (cdb_gnt) begin
            if (sb[0].cyc >= 0) check("cdb_cycle", 32'(cyc), 32'(sb[0].cyc));
            void'(sb.pop_front());
          end
        end
      end
    end
  endtask

  // Drives one issue for a cycle; acc is whether the unit should accept it.
  task automatic do_issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] pr, input logic [4:0] rob,
                          input logic [31:0] res, input bit acc, input int lat);
    issue_valid   = 1'b1;
    issue_func    = f;
    issue_opa     = a;
    issue_opb     = b;
    issue_pr_idx  = pr;
    issue_rob_idx = rob;
    @(negedge clock);
    check("issue_busy", 32'(busy), 32'(!acc));
    if (acc && !squash) sb.push_back('{res, pr, rob, (lat >= 0) ? (cyc + lat) : -1});
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    tick();
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; squash = 1'b0; issue_valid = 1'b0; cdb_gnt = 1'b0;
    issue_func = MUL; issue_opa = '0; issue_opb = '0; issue_pr_idx = '0; issue_rob_idx = '0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cdb_req", 32'(cdb_req), 32'd0);
    check("rst_result", cdb_result, 32'd0);
    check("rst_pr_idx", 32'(cdb_pr_idx), 32'd0);
    check("rst_rob_idx", 32'(cdb_rob_idx), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Basic latency: request four cycles after issue, gone the cycle after grant.
    cdb_gnt = 1'b1;
    do_issue(MUL, 32'd7, 32'd6, 6'd5, 5'd3, 32'h0000002A, 1'b1, 4);
    repeat (4) @(negedge clock);
    @(negedge clock);
    check("basic_req_after_gnt", 32'(cdb_req), 32'd0);
    wait_drain();

    // Signedness and slice coverage, back to back under continuous grant.
    do_issue(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1, 5'd1, 32'h00000000, 1'b1, 4);
    do_issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 5'd2, 32'hFFFFFFFE, 1'b1, 4);
    do_issue(MULHSU, 32'hFFFFFFFF, 32'h00000002, 6'd3, 5'd3, 32'hFFFFFFFF, 1'b1, 4);
    do_issue(MUL,    32'h80000000, 32'hFFFFFFFF, 6'd4, 5'd4, 32'h80000000, 1'b1, 4);
    do_issue(MULH,   32'h80000000, 32'h80000000, 6'd5, 5'd5, 32'h40000000, 1'b1, 4);
    do_issue(MULHU,  32'h80000000, 32'h00000002, 6'd6, 5'd6, 32'h00000001, 1'b1, 4);
    do_issue(MULHSU, 32'h80000000, 32'hFFFFFFFF, 6'd7, 5'd7, 32'h80000000, 1'b1, 4);
    do_issue(MUL,    32'h0000FFFF, 32'h00010001, 6'd8, 5'd8, 32'hFFFFFFFF, 1'b1, 4);
    wait_drain();

    // Backpressure: fifth issue refused, held output stable, in-order drain.
    cdb_gnt = 1'b0;
    do_issue(MUL,   32'd3,        32'd5,        6'd10, 5'd10, 32'h0000000F, 1'b1, -1);
    do_issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd11, 5'd11, 32'hFFFFFFFE, 1'b1, -1);
    do_issue(MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd12, 5'd12, 32'h00000001, 1'b1, -1);
    do_issue(MULH,  32'h7FFFFFFF, 32'h7FFFFFFF, 6'd13, 5'd13, 32'h3FFFFFFF, 1'b1, -1);
    do_issue(MUL,   32'd1,        32'd1,        6'd14, 5'd14, 32'h00000001, 1'b0, -1);
    repeat (3) tick();
    cdb_gnt = 1'b1;
    g = cyc;
    for (int i = 0; i < sb.size(); i++) sb[i].cyc = g + i;
    wait_drain();

    // Full pipe then grant plus issue in the same cycle.
    cdb_gnt = 1'b0;
    do_issue(MUL,    32'd100,      32'd100,      6'd20, 5'd20, 32'h00002710, 1'b1, -1);
    do_issue(MULHU,  32'h80000000, 32'h80000000, 6'd21, 5'd21, 32'h40000000, 1'b1, -1);
    do_issue(MULH,   32'hFFFFFFFE, 32'h00000003, 6'd22, 5'd22, 32'hFFFFFFFF, 1'b1, -1);
    do_issue(MULHSU, 32'h00000002, 32'h80000000, 6'd23, 5'd23, 32'h00000001, 1'b1, -1);
    @(negedge clock);
    check("full_busy", 32'(busy), 32'd1);
    check("full_req", 32'(cdb_req), 32'd1);
    tick();
    cdb_gnt = 1'b1;
    g = cyc;
    for (int i = 0; i < sb.size(); i++) sb[i].cyc = g + i;
    do_issue(MUL, 32'h00010000, 32'h00010000, 6'd24, 5'd24, 32'h00000000, 1'b1, 4);
    wait_drain();

    // Squash with three in flight and an issue in the squash cycle.
    do_issue(MUL, 32'd2, 32'd3, 6'd30, 5'd30, 32'd6,  1'b1, 4);
    do_issue(MUL, 32'd4, 32'd5, 6'd31, 5'd31, 32'd20, 1'b1, 4);
    do_issue(MUL, 32'd6, 32'd7, 6'd32, 5'd0,  32'd42, 1'b1, 4);
    squash = 1'b1;
    do_issue(MUL, 32'd8, 32'd9, 6'd33, 5'd1, 32'd72, 1'b1, 4);
    squash = 1'b0;
    sb.delete();
    @(negedge clock);
    check("squash_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("squash_no_req", 32'(cdb_req), 32'd0);
      @(negedge clock);
    end
    tick();

    // Asynchronous reset in the middle of an operation.
    do_issue(MUL, 32'd7, 32'd6, 6'd5, 5'd3, 32'h0000002A, 1'b1, 4);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("arst_req", 32'(cdb_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", cdb_result, 32'd0);
    sb.delete();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("arst_no_req", 32'(cdb_req), 32'd0);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply functional unit directly downstream of the reservation station issue port.
- Accepts at most one multiply issue per cycle with operands already read from the physical register file.
- Computes the RV32M MUL/MULH/MULHSU/MULHU result over N_STAGES pipeline stages.
- Holds the finished result until the CDB arbiter grants it; drives the busy flag the reservation station samples when selecting mult issues.

Parameters:
- XLEN, 32, operand and result width.
- N_STAGES, 4, pipeline depth; must divide 2*XLEN evenly; each stage consumes a 2*XLEN/N_STAGES-bit slice of the multiplier.
- PR_IDX_W, 6, physical register tag width.
- ROB_IDX_W, 5, ROB index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- squash  in  1  mispredict flush; kills all in-flight ops.
- issue_valid  in  1  issue request from reservation station.
- issue_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- issue_opa  in  XLEN  multiplicand (rs1 value).
- issue_opb  in  XLEN  multiplier (rs2 value).
- issue_pr_idx  in  PR_IDX_W  destination physical register.
- issue_rob_idx  in  ROB_IDX_W  ROB entry.
- busy  out  1  issue would not be accepted this cycle.
- cdb_req  out  1  completed result waiting in final stage.
- cdb_gnt  in  1  CDB grant for this unit, same cycle as cdb_req.
- cdb_result  out  XLEN  completed result.
- cdb_pr_idx  out  PR_IDX_W  tag of completed result.
- cdb_rob_idx  out  ROB_IDX_W  ROB index of completed result.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits clear.
- Outputs under reset: busy=0, cdb_req=0, cdb_result/cdb_pr_idx/cdb_rob_idx=0. Stage data contents are don't-care but outputs are forced to 0 when stage N_STAGES is invalid.
- Stage k (1..N_STAGES) holds: valid, func, pr_idx, rob_idx, the 2*XLEN extended multiplicand, the 2*XLEN extended multiplier, and the partial product after k slices.
- Operand extension at issue:
  - opa is sign-extended for MUL, MULH, MULHSU; zero-extended for MULHU.
  - opb is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
- Partial product: stage k's partial = stage k-1's partial + (mcand * slice_{k-1} of mplier) << ((k-1)*slice width), all mod 2^(2*XLEN). Stage 1 computes slice 0 directly from the issue inputs.
- Result selection: MUL gives the low XLEN bits of the final product; MULH, MULHSU and MULHU give the high XLEN bits.
- Advance rules:
  - Final stage advances (vacates) when ~valid or cdb_gnt.
  - Stage k<N_STAGES advances when ~valid or stage k+1 advances.
  - A stage that cannot advance holds all its contents unchanged.
- busy = valid[1] & ~advance[1], combinational. The issue is accepted on the edge when issue_valid & ~busy; it is captured into stage 1.
- issue_valid while busy=1: the request is ignored and the RS is responsible for retry. busy must not depend combinationally on issue_valid.
- Latency: an issue accepted at the edge ending cycle t raises cdb_req in cycle t+N_STAGES when no backpressure occurs. Throughput is 1 op per cycle while cdb_gnt is held high.
- cdb_req = valid[N_STAGES]. cdb_result and the tags are driven from the final stage and stay stable while cdb_req=1 and cdb_gnt=0.
- cdb_gnt while cdb_req=0 is ignored.
- Full pipeline: all stages valid and cdb_gnt=0 means no stage moves and busy=1.
- Grant with a full pipeline: every stage shifts in the same edge and busy=0 in that cycle, so an issue in that cycle is accepted.
- squash=1: all valid bits clear at the edge. An issue in the same cycle is dropped, and cdb_req is 0 from the next cycle.
- Squash and grant in the same cycle: the granted result is still considered broadcast by the arbiter. The unit only clears its state.
- Ordering: results complete strictly in issue order; there is no bypass past a held final stage.

Test Plan:
- Reset mid-operation: issue MUL 7*6, then assert reset=0 asynchronously in cycle t+2 → cdb_req=0 and busy=0 immediately, and no result ever appears.
- Basic latency: issue MUL opa=7, opb=6, pr_idx=5, rob_idx=3 in cycle 0 → cdb_req=1 in cycle 4 with cdb_result=0x0000002A, pr_idx=5, rob_idx=3. With cdb_gnt=1, cdb_req=0 in cycle 5.
- Signedness:
  - MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000.
  - MULHU on the same operands → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0x00000002 → 0xFFFFFFFF.
  - MUL 0x80000000*0xFFFFFFFF → 0x80000000.
- Backpressure: issue 5 back-to-back ops with cdb_gnt=0 → the 5th issue sees busy=1 and is ignored, and the final-stage outputs stay stable. Raising cdb_gnt then drains the 4 results in issue order on consecutive cycles.
- Squash: 3 ops in flight plus a new issue in the squash cycle → no cdb_req afterwards, and busy=0 the following cycle.
- Full-pipe grant: pipeline full, cdb_gnt=1 and issue_valid=1 in the same cycle → busy=0 and the issue is accepted; it completes 4 cycles later if grants continue.
